td_reset_seq: RTL and testbench
===============================

TD_RESET_SEQ -- requirements
Module: td_reset_seq

Interface
REQ-001 The module SHALL have parameter N_CH, default 2, giving the number of decoder reset channels (1..8).
REQ-002 The module SHALL have parameter DEBOUNCE_CYC, default 1000, giving the cycles sw must be stable high before a trigger (>=1).
REQ-003 The module SHALL have parameter DELAY_CYC, default 700000, giving the cycles from trigger acceptance to reset assertion (>=1).
REQ-004 The module SHALL have parameter PULSE_CYC, default 700000, giving the cycles channel 0 is held in reset (>=1).
REQ-005 The module SHALL have parameter STAGGER_CYC, default 0, giving the release spacing between consecutive channels (>=0).
REQ-006 The module SHALL have port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 The module SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port sw, input, 1 bit: asynchronous switch or button request.
REQ-009 The module SHALL have port trig, input, 1 bit: synchronous single-cycle software trigger.
REQ-010 The module SHALL have port ch_mask, input, N_CH bits: channels to reset, sampled at trigger acceptance.
REQ-011 The module SHALL have port ch_nreset, output, N_CH bits: active-low decoder resets, registered.
REQ-012 The module SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-014 The module SHALL have port trig_lost, output, 1 bit: one-cycle pulse when a trigger is dropped.

Function
REQ-015 sw SHALL pass through a 2-flop synchroniser (sw_s) before any use.
REQ-016 The debounce counter SHALL increment while sw_s=1, clear when sw_s=0, and saturate; sw_req SHALL fire once when the counter reaches DEBOUNCE_CYC.
REQ-017 After firing, sw_req SHALL NOT fire again until sw_s has returned to 0 (rearm latch), so that holding the switch yields exactly one sequence.
REQ-018 The state machine SHALL have states IDLE, DELAY, PULSE, RELEASE.
REQ-019 In IDLE, a trigger (trig=1 or sw_req) with ch_mask!=0 SHALL be accepted at edge t0: mask_q<=ch_mask, counter<=0, state<=DELAY, busy<=1.
REQ-020 A trigger in IDLE with ch_mask==0 SHALL be ignored with no output change and no trig_lost.
REQ-021 A trigger in any non-IDLE state SHALL be dropped and SHALL pulse trig_lost for one cycle; the running sequence SHALL be unaffected.
REQ-022 In DELAY, after DELAY_CYC cycles: ch_nreset[i]<=0 for every i with mask_q[i]=1 (at edge t0+DELAY_CYC), then state<=PULSE.
REQ-023 In PULSE, after PULSE_CYC cycles the state SHALL go to RELEASE with channel index 0.
REQ-024 Masked channel i SHALL return high at edge t0+DELAY_CYC+PULSE_CYC+i*STAGGER_CYC; index slots for unmasked channels still consume STAGGER_CYC cycles.
REQ-025 With STAGGER_CYC=0, all masked channels SHALL release on the same edge.
REQ-026 On the edge that releases the last index (N_CH-1), done<=1 for one cycle, busy<=0, and state<=IDLE; a new trigger SHALL be acceptable on the next edge.
REQ-027 Unmasked channels SHALL hold ch_nreset=1 throughout.
REQ-028 Counter width SHALL be $clog2(max(DELAY_CYC,PULSE_CYC,STAGGER_CYC,DEBOUNCE_CYC)+1), and counters SHALL never wrap.

Reset
REQ-029 While nreset=0: ch_nreset=all 1, busy=0, done=0, trig_lost=0, state=IDLE, all counters 0, synchroniser 0, and the rearm latch cleared.
REQ-030 Assertion of nreset mid-sequence SHALL release all channels immediately (asynchronously); no done pulse SHALL be generated.
REQ-031 After nreset deasserts, a sw held high SHALL be debounced afresh before it can trigger.

Verification (N_CH=3, DEBOUNCE_CYC=5, DELAY_CYC=4, PULSE_CYC=6, STAGGER_CYC=3)
REQ-032 trig at edge 0, ch_mask=3'b111 -> ch_nreset=000 after edge 4; ch0 high after edge 10, ch1 after edge 13, ch2 after edge 16; done for one cycle after edge 16; busy high over edges 1..15.
REQ-033 sw high 4 cycles then low -> no trigger; sw high held 20 cycles -> exactly one sequence; release and re-press -> a second sequence.
REQ-034 trig with ch_mask=3'b010 -> only ch1 goes low (edges 4..13); ch0 and ch2 stay 1; done after edge 16.
REQ-035 trig at edge 0, second trig at edge 7 -> trig_lost pulse after edge 7; timing identical to REQ-032.
REQ-036 nreset low at edge 8 of a sequence -> ch_nreset=111 immediately, busy=0, no done; trig after reset release -> a full, correct sequence.
REQ-037 trig with ch_mask=0 -> no output activity, busy=0, trig_lost=0.

Source files
------------

// File: rtl/td_reset_seq.sv
// Decoder reset sequencer: a debounced switch or a software trigger starts a
// delay, then holds the masked channels in reset and releases them in index order.
module td_reset_seq #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000,
    parameter int unsigned DELAY_CYC    = 700000,
    parameter int unsigned PULSE_CYC    = 700000,
    parameter int unsigned STAGGER_CYC  = 0
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            sw,
    input  logic            trig,
    input  logic [N_CH-1:0] ch_mask,
    output logic [N_CH-1:0] ch_nreset,
    output logic            busy,
    output logic            done,
    output logic            trig_lost
);

    localparam int unsigned MAX_DP  = (DELAY_CYC > PULSE_CYC) ? DELAY_CYC : PULSE_CYC;
    localparam int unsigned MAX_SD  = (STAGGER_CYC > DEBOUNCE_CYC) ? STAGGER_CYC : DEBOUNCE_CYC;
    localparam int unsigned MAX_CYC = (MAX_DP > MAX_SD) ? MAX_DP : MAX_SD;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned IW      = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0] DEB_FULL   = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] STAG_LAST  = CW'((STAGGER_CYC > 0) ? STAGGER_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_CH - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StPulse, StRelease} state_t;

    // Switch synchroniser and debounce
    logic          sw_meta, sw_s;
    logic [CW-1:0] deb_cnt_q;
    logic          fired_q;
    logic          sw_req;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    // fired_q blocks repeat requests until the switch is seen released
    assign sw_req = !fired_q && (deb_cnt_q == DEB_FULL);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            deb_cnt_q <= '0;
            fired_q   <= 1'b0;
        end else begin
            if (!sw_s) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q != DEB_FULL) begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            if (!sw_s) begin
                fired_q <= 1'b0;
            end else if (sw_req) begin
                fired_q <= 1'b1;
            end
        end
    end

    // Sequencer
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] chn_q, chn_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            lost_q, lost_d;
    logic            trigger;

    assign trigger = trig || sw_req;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            chn_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            chn_q   <= chn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        chn_d   = chn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lost_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trigger && (ch_mask != '0)) begin
                    mask_d  = ch_mask;
                    cnt_d   = '0;
                    state_d = StDelay;
                    busy_d  = 1'b1;
                end
            end
            StDelay: begin
                if (cnt_q == DELAY_LAST) begin
                    chn_d   = ~mask_q;
                    cnt_d   = '0;
                    state_d = StPulse;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if ((N_CH == 1) || (STAGGER_CYC == 0)) begin
                        chn_d   = '1;
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Channel 0 goes on this edge; RELEASE walks indices 1..N_CH-1
                        chn_d[0] = 1'b1;
                        idx_d    = IW'(1);
                        state_d  = StRelease;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (cnt_q == STAG_LAST) begin
                    cnt_d        = '0;
                    chn_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q != StIdle) && trigger) begin
            lost_d = 1'b1;
        end
    end

    assign ch_nreset = chn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign trig_lost = lost_q;

endmodule

// File: tb/tb_td_reset_seq.sv
// Bench for td_reset_seq: a timeline model predicts every output change, and a
// negedge monitor matches each observed change against the predicted queue.
module tb_td_reset_seq;

    localparam int N   = 3;
    localparam int DEB = 5;
    localparam int DLY = 4;
    localparam int PUL = 6;
    localparam int STG = 3;
    localparam int SEQ_LEN = DLY + PUL + (N - 1) * STG;

    logic         clock = 1'b0;
    logic         nreset = 1'b0;
    logic         sw = 1'b0;
    logic         trig = 1'b0;
    logic [N-1:0] ch_mask = '0;
    logic [N-1:0] ch_nreset;
    logic         busy, done, trig_lost;

    td_reset_seq #(
        .N_CH        (N),
        .DEBOUNCE_CYC(DEB),
        .DELAY_CYC   (DLY),
        .PULSE_CYC   (PUL),
        .STAGGER_CYC (STG)
    ) dut (
        .clock    (clock),
        .nreset   (nreset),
        .sw       (sw),
        .trig     (trig),
        .ch_mask  (ch_mask),
        .ch_nreset(ch_nreset),
        .busy     (busy),
        .done     (done),
        .trig_lost(trig_lost)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Signal ids: 0..N-1 channel bits, N busy, N+1 done, N+2 trig_lost
    typedef struct packed {
        int   cyc;
        int   sig;
        logic val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: one sequence at a time, plus the last dropped trigger
    int           seq_t0 = -100;
    int           seq_tend = -100;
    logic [N-1:0] seq_mask = '0;
    int           last_lost = -100;

    function automatic string sig_name(input int s);
        if (s < N) return $sformatf("ch_nreset[%0d]", s);
        if (s == N) return "busy";
        if (s == N + 1) return "done";
        return "trig_lost";
    endfunction

    task automatic push_ev(input int c, input int s, input logic v);
        ev_t e;
        int  k;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        k = exp_q.size();
        while (k > 0 && (exp_q[k-1].cyc > c || (exp_q[k-1].cyc == c && exp_q[k-1].sig > s)))
            k--;
        exp_q.insert(k, e);
    endtask

    // A trigger seen on edge c: dropped if a sequence spans c, else started if mask nonzero
    task automatic model_trigger(input int c, input logic [N-1:0] m);
        if (c >= seq_t0 && c <= seq_tend) begin
            push_ev(c, N + 2, 1'b1);
            push_ev(c + 1, N + 2, 1'b0);
            last_lost = c;
        end else if (m != '0) begin
            seq_t0   = c;
            seq_tend = c + SEQ_LEN;
            seq_mask = m;
            push_ev(c, N, 1'b1);
            push_ev(seq_tend, N, 1'b0);
            push_ev(seq_tend, N + 1, 1'b1);
            push_ev(seq_tend + 1, N + 1, 1'b0);
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    push_ev(c + DLY, i, 1'b0);
                    push_ev(c + DLY + PUL + i * STG, i, 1'b1);
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_trig(input logic [N-1:0] m);
        trig    = 1'b1;
        ch_mask = m;
        model_trigger(cyc + 1, m);
        tick(1);
        trig = 1'b0;
    endtask

    task automatic press_sw(input int hold);
        sw = 1'b1;
        // two synchroniser flops, DEB stable cycles, then one cycle to accept
        if (hold >= DEB) model_trigger(cyc + 3 + DEB, ch_mask);
        tick(hold);
        sw = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ch_nreset"}, int'(ch_nreset), (1 << N) - 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_trig_lost"}, int'(trig_lost), 0);
    endtask

    task automatic do_reset(input int hold);
        int e;
        int p;
        e = cyc;
        p = e - 1;
        nreset = 1'b0;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].cyc >= e) exp_q.delete(k);
        end
        for (int i = 0; i < N; i++) begin
            if (seq_mask[i] && p >= seq_t0 + DLY && p < seq_t0 + DLY + PUL + i * STG)
                push_ev(e, i, 1'b1);
        end
        if (p >= seq_t0 && p < seq_tend) push_ev(e, N, 1'b0);
        if (p == seq_tend) push_ev(e, N + 1, 1'b0);
        if (p == last_lost) push_ev(e, N + 2, 1'b0);
        seq_t0    = -100;
        seq_tend  = -100;
        last_lost = -100;
        #1;
        reset_checks("async_reset");
        tick(hold);
        nreset = 1'b1;
    endtask

    // Monitor: every output change must be the next predicted event
    logic [N+2:0] prev_obs = {3'b000, {N{1'b1}}};
    logic [N+2:0] obs;

    always @(negedge clock) begin : monitor
        obs = {trig_lost, done, busy, ch_nreset};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s at cycle %0d: got no change, required %b",
                     sig_name(exp_q[0].sig), exp_q[0].cyc, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        for (int s = 0; s < N + 3; s++) begin
            if (obs[s] !== prev_obs[s]) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].sig == s &&
                    exp_q[0].val === obs[s]) begin
                    void'(exp_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %b, required %b", sig_name(s), cyc,
                             obs[s], prev_obs[s]);
                end
            end
        end
        prev_obs = obs;
    end

    initial begin
        logic [N-1:0] m;
        tick(3);
        reset_checks("power_on");
        nreset = 1'b1;
        tick(2);

        // Full sequence, single channel, dropped trigger mid-sequence
        do_trig(3'b111);
        tick(25);
        do_trig(3'b010);
        tick(25);
        do_trig(3'b111);
        tick(6);
        do_trig(3'b101);
        tick(25);

        // Reset on edge 8 of a sequence, then a clean sequence
        do_trig(3'b111);
        tick(8);
        do_reset(3);
        tick(2);
        do_trig(3'b111);
        tick(25);

        // Empty mask is ignored
        do_trig(3'b000);
        tick(3);
        check("empty_mask_busy", int'(busy), 0);
        check("empty_mask_trig_lost", int'(trig_lost), 0);
        check("empty_mask_ch_nreset", int'(ch_nreset), (1 << N) - 1);

        // Switch: short press, long hold, re-press
        ch_mask = 3'b101;
        press_sw(4);
        tick(10);
        press_sw(20);
        tick(30);
        press_sw(8);
        tick(30);

        // Randomised triggers with occasional resets
        for (int it = 0; it < 40; it++) begin
            tick($urandom_range(1, 12));
            if ($urandom_range(0, 9) == 0) begin
                do_reset($urandom_range(1, 3));
                tick(1);
            end
            m = N'($urandom_range(0, 7));
            do_trig(m);
        end
        tick(40);

        check("pending_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
